// File: rtl/crc8_frame_ctrl.sv
// Framed CRC-8 (x^8+x^5+x^4+1) generator/checker with a byte-wide valid/ready input.
// Define CRC8_PARALLEL_EN to fold all eight bit-updates of a byte into a single SHIFT cycle.
module crc8_frame_ctrl #(
  parameter logic [7:0] SEED = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       check,
  input  logic [3:0] len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] crc_out,
  output logic       crc_ok,
  output logic [3:0] byte_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t     state, state_next;
  logic [7:0] crc;
  logic [7:0] shreg;
  logic [4:0] cnt;
  logic [4:0] target;
  logic [4:0] target_in;
  logic       check_l;
  logic       crc_ok_q;
  logic       shift_last;
  logic [7:0] crc_shift;
`ifndef CRC8_PARALLEL_EN
  logic [2:0] bit_cnt;
`endif

  // One LFSR step with d as the incoming message bit.
  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic d);
    logic fb;
    fb = c[7] ^ d;
    return {c[6], c[5], c[4] ^ fb, c[3] ^ fb, c[2], c[1], c[0], fb};
  endfunction

  // Frame length includes the trailing received-CRC byte in check mode; 5 bits so 15+1 fits.
  assign target_in = {1'b0, len} + {4'b0000, check};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    crc_shift = crc;
`ifdef CRC8_PARALLEL_EN
    for (int i = 7; i >= 0; i--) begin
      crc_shift = crc_bit(crc_shift, shreg[i]);
    end
    shift_last = 1'b1;
`else
    crc_shift  = crc_bit(crc, shreg[7]);
    shift_last = (bit_cnt == 3'd7);
`endif
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = (target_in == 5'd0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (shift_last) state_next = (cnt == target) ? S_DONE : S_LOAD;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc      <= 8'h00;
      shreg    <= 8'h00;
      cnt      <= 5'd0;
      target   <= 5'd0;
      check_l  <= 1'b0;
      crc_ok_q <= 1'b0;
      byte_cnt <= 4'd0;
`ifndef CRC8_PARALLEL_EN
      bit_cnt  <= 3'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            crc      <= SEED;
            cnt      <= 5'd0;
            target   <= target_in;
            check_l  <= check;
            crc_ok_q <= 1'b0;
            byte_cnt <= 4'd0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            shreg    <= in_data;
            cnt      <= cnt + 5'd1;
            byte_cnt <= byte_cnt + 4'd1;
`ifndef CRC8_PARALLEL_EN
            bit_cnt  <= 3'd0;
`endif
          end
        end
        S_SHIFT: begin
          crc <= crc_shift;
`ifndef CRC8_PARALLEL_EN
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
`endif
        end
        S_DONE: crc_ok_q <= check_l & (crc == 8'h00);
        default: ;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign crc_out = crc;
  // Result is valid during the done pulse itself and then held until the next start.
  assign crc_ok  = done ? (check_l & (crc == 8'h00)) : crc_ok_q;

endmodule
